pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; word-aligned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PCWre  input  1  from control unit; 0 = halt instruction decoded, PC frozen.
REQ-005 PCSrc  input  1  from control unit; 1 = taken branch, PC loads branch target.
REQ-006 ExtSel  input  1  from control unit; 1 = sign-extend instr[15:0], 0 = zero-extend.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  read address; equals pc while imem_req is high.
REQ-009 imem_ack  input  1  memory returns data this cycle.
REQ-010 imem_rdata  input  32  instruction word; valid only when imem_ack=1.
REQ-011 pc  output  32  address of the current instruction.
REQ-012 instr  output  32  latched instruction word.
REQ-013 op  output  6  instr[31:26], feeds control unit op input.
REQ-014 ext_imm  output  32  instr[15:0] extended per ExtSel, combinational from instr.
REQ-015 instr_valid  output  1  high for exactly one cycle per instruction (execute cycle).
REQ-016 halted  output  1  high while in HALT state.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, EXEC, HALT; encoding is free.
REQ-018 IDLE SHALL last one cycle after reset deassertion, then go to FETCH.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; state held until imem_ack=1.
REQ-020 On the FETCH cycle with imem_ack=1, instr SHALL load imem_rdata and state SHALL go to EXEC next cycle.
REQ-021 imem_req SHALL be 0 in IDLE, EXEC and HALT; imem_ack in those states SHALL be ignored (instr unchanged).
REQ-022 In EXEC, instr_valid SHALL be 1; PCWre, PCSrc, ExtSel SHALL be sampled in this cycle only.
REQ-023 EXEC with PCWre=0: pc SHALL be unchanged, next state HALT.
REQ-024 EXEC with PCWre=1, PCSrc=0: pc SHALL become pc+4, next state FETCH.
REQ-025 EXEC with PCWre=1, PCSrc=1: pc SHALL become pc+4+(sign_extend(instr[15:0])<<2), next state FETCH.
REQ-026 Branch offset SHALL always be sign-extended regardless of ExtSel; ExtSel affects ext_imm only.
REQ-027 PC arithmetic SHALL be modulo 2^32; wrap from 32'hFFFF_FFFC+4 to 0 without error.
REQ-028 PCWre=0 SHALL take priority over PCSrc=1 (halt wins, no branch).
REQ-029 HALT SHALL be absorbing; only reset leaves it; halted=1, pc and instr held.
REQ-030 Minimum latency per instruction SHALL be 2 cycles (FETCH with immediate ack, then EXEC); each wait cycle without ack adds 1.
REQ-031 op SHALL always equal instr[31:26]; ext_imm SHALL be {16{instr[15]},instr[15:0]} when ExtSel=1, else {16'h0,instr[15:0]}.

Reset
REQ-032 On reset=1 at a clock edge: state IDLE, pc=RESET_PC, instr=0, instr_valid=0, halted=0, imem_req=0.
REQ-033 Reset SHALL override every state including mid-FETCH with ack pending and HALT; an ack on the reset cycle SHALL be discarded.
REQ-034 Reset held for multiple cycles SHALL keep all outputs at reset values.

Verification
REQ-035 Reset release, imem_ack=1 immediately, rdata=32'h0000_0000 (add), PCWre=1, PCSrc=0 -> imem_addr 0, then 4, then 8; instr_valid every 2nd cycle.
REQ-036 Memory acks after 3 wait cycles -> imem_req high 4 cycles at constant imem_addr, instr_valid one cycle, pc unchanged until EXEC.
REQ-037 pc=32'h10, instr=32'hC000_FFFE (beq, offset -2), PCSrc=1 -> next pc=32'h0C; with offset 16'h0003 -> pc=32'h20.
REQ-038 instr=32'hFC00_0000 with PCWre=0 and PCSrc=1 in EXEC -> pc held, halted=1, imem_req stays 0 for 10+ cycles despite imem_ack pulses.
REQ-039 Reset asserted during FETCH while imem_ack=1 -> instr stays 0, pc=RESET_PC, state IDLE then FETCH at RESET_PC.
REQ-040 RESET_PC=32'hFFFF_FFFC, sequential instruction -> pc wraps to 32'h0000_0000; ExtSel=0 with instr[15:0]=16'h8001 -> ext_imm=32'h0000_8001, ExtSel=1 -> 32'hFFFF_8001.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch sequencer: fetches one word per
// instruction over a request/ack memory port, then holds it for one execute cycle.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWre,
  input  logic        PCSrc,
  input  logic        ExtSel,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] ext_imm,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic        req_reg;
  logic        valid_reg;
  logic        halted_reg;

  logic [31:0] seq_pc_next;
  logic [31:0] branch_off;
  logic [31:0] branch_pc_next;
  logic [31:0] pc_next;

  // Branch offset is always sign-extended; ExtSel only shapes ext_imm.
  assign seq_pc_next    = pc_reg + 32'd4;
  assign branch_off     = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
  assign branch_pc_next = seq_pc_next + branch_off;
  assign pc_next        = PCSrc ? branch_pc_next : seq_pc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= RESET_PC;
      instr_reg  <= 32'h0;
      req_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_FETCH;
          req_reg   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr_reg <= imem_rdata;
            state_reg <= ST_EXEC;
            req_reg   <= 1'b0;
            valid_reg <= 1'b1;
          end
        end
        ST_EXEC: begin
          valid_reg <= 1'b0;
          if (!PCWre) begin
            // Halt has priority over a taken branch.
            state_reg  <= ST_HALT;
            halted_reg <= 1'b1;
          end else begin
            pc_reg    <= pc_next;
            state_reg <= ST_FETCH;
            req_reg   <= 1'b1;
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        default: begin
          state_reg <= ST_IDLE;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign op          = instr_reg[31:26];
  assign instr_valid = valid_reg;
  assign halted      = halted_reg;

  assign ext_imm[15:0] = instr_reg[15:0];
  generate
    for (genvar gi = 16; gi < 32; gi++) begin : g_ext
      assign ext_imm[gi] = ExtSel & instr_reg[15];
    end
  endgenerate

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential flow, wait states, branches, halt,
// reset mid-fetch and PC wrap on a second instance reset to 32'hFFFF_FFFC.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset, PCWre, PCSrc, ExtSel, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, pc, instr, ext_imm;
  logic [5:0]  op;

  logic        w_reset, w_ack;
  logic [31:0] w_rdata;
  logic        w_req, w_valid, w_halted;
  logic [31:0] w_addr, w_pc, w_instr, w_ext_imm;
  logic [5:0]  w_op;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk(clk), .reset(reset), .PCWre(PCWre), .PCSrc(PCSrc), .ExtSel(ExtSel),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .op(op), .ext_imm(ext_imm),
    .instr_valid(instr_valid), .halted(halted)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_reset), .PCWre(PCWre), .PCSrc(PCSrc), .ExtSel(ExtSel),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .pc(w_pc), .instr(w_instr), .op(w_op), .ext_imm(w_ext_imm),
    .instr_valid(w_valid), .halted(w_halted)
  );

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Drives one instruction from a FETCH cycle through its EXEC cycle.
  task automatic exec_instr(input logic [31:0] word, input logic wre, input logic src);
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0; PCWre = wre; PCSrc = src;
    step();
    PCWre = 1'b1; PCSrc = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; w_reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (pc !== 32'h0 || instr !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got pc=%h instr=%h req=%b valid=%b halted=%b, want 0/0/0/0/0",
                 i, pc, instr, imem_req, instr_valid, halted);
      end
      vectors++;
      if (w_pc !== 32'hFFFF_FFFC || w_req !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_wrap_pc[%0d]: got pc=%h req=%b, want fffffffc/0", i, w_pc, w_req);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_sequential;
    logic [31:0] exp_pc;
    logic        exp_req;
    imem_ack = 1'b1; imem_rdata = 32'h0; PCWre = 1'b1; PCSrc = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_pc  = 32'(i / 2) * 32'd4;
      exp_req = (i % 2 == 0);
      vectors++;
      if (imem_req !== exp_req || instr_valid !== !exp_req || imem_addr !== exp_pc || pc !== exp_pc) begin
        miscompares++;
        $display("FAIL seq[%0d]: got req=%b valid=%b addr=%h pc=%h, want req=%b valid=%b addr=%h",
                 i, imem_req, instr_valid, imem_addr, pc, exp_req, !exp_req, exp_pc);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_wait_states;
    reset = 1'b1; imem_ack = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL wait[%0d]: got req=%b addr=%h valid=%b, want 1/00000000/0", i, imem_req, imem_addr, instr_valid);
      end
      if (i == 3) begin
        imem_ack = 1'b1; imem_rdata = 32'h2400_8001;
      end
    end
    step();
    imem_ack = 1'b0; ExtSel = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h2400_8001 || op !== 6'h09) begin
      miscompares++;
      $display("FAIL wait_exec: got valid=%b pc=%h instr=%h op=%h, want 1/00000000/24008001/09", instr_valid, pc, instr, op);
    end
    vectors++;
    if (ext_imm !== 32'h0000_8001) begin
      miscompares++;
      $display("FAIL ext_zero: got %h want 00008001", ext_imm);
    end
    ExtSel = 1'b1;
    #1;
    vectors++;
    if (ext_imm !== 32'hFFFF_8001) begin
      miscompares++;
      $display("FAIL ext_sign: got %h want ffff8001", ext_imm);
    end
    step();
    vectors++;
    if (instr_valid !== 1'b0 || pc !== 32'h4 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_after: got valid=%b pc=%h req=%b, want 0/00000004/1", instr_valid, pc, imem_req);
    end
  endtask

  task automatic test_branch;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) exec_instr(32'h0, 1'b1, 1'b0);
    vectors++;
    if (pc !== 32'h10) begin
      miscompares++;
      $display("FAIL br_setup: got pc=%h want 00000010", pc);
    end
    ExtSel = 1'b0;
    exec_instr(32'hC000_FFFE, 1'b1, 1'b1);
    vectors++;
    if (pc !== 32'h0C || imem_addr !== 32'h0C || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL br_back: got pc=%h addr=%h req=%b, want 0000000c/0000000c/1", pc, imem_addr, imem_req);
    end
    exec_instr(32'h0, 1'b1, 1'b0);
    ExtSel = 1'b1;
    exec_instr(32'hC000_0003, 1'b1, 1'b1);
    vectors++;
    if (pc !== 32'h20) begin
      miscompares++;
      $display("FAIL br_fwd: got pc=%h want 00000020", pc);
    end
  endtask

  task automatic test_halt;
    exec_instr(32'hFC00_0000, 1'b0, 1'b1);
    vectors++;
    if (pc !== 32'h20 || halted !== 1'b1 || imem_req !== 1'b0 || op !== 6'h3F) begin
      miscompares++;
      $display("FAIL halt_enter: got pc=%h halted=%b req=%b op=%h, want 00000020/1/0/3f", pc, halted, imem_req, op);
    end
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      imem_ack = (i % 2 == 0);
      step();
      vectors++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 32'h20 || instr !== 32'hFC00_0000 || instr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_hold[%0d]: got req=%b halted=%b pc=%h instr=%h valid=%b", i, imem_req, halted, pc, instr, instr_valid);
      end
    end
    imem_ack = 1'b0; reset = 1'b1;
    step();
    vectors++;
    if (halted !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
      miscompares++;
      $display("FAIL halt_reset: got halted=%b pc=%h instr=%h, want 0/00000000/00000000", halted, pc, instr);
    end
  endtask

  task automatic test_reset_mid_fetch;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    exec_instr(32'h1111_1111, 1'b1, 1'b0);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL rst_pre: got req=%b addr=%h instr=%h, want 1/00000004/11111111", imem_req, imem_addr, instr);
    end
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    step();
    vectors++;
    if (instr !== 32'h0 || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_fetch: got instr=%h pc=%h req=%b valid=%b, want 0/0/0/0", instr, pc, imem_req, instr_valid);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_idle: got req=%b addr=%h instr=%h, want 1/00000000/00000000", imem_req, imem_addr, instr);
    end
    step();
    imem_ack = 1'b0;
    vectors++;
    if (instr !== 32'hAAAA_5555 || instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_refetch: got instr=%h valid=%b, want aaaa5555/1", instr, instr_valid);
    end
  endtask

  task automatic test_wrap;
    PCWre = 1'b1; PCSrc = 1'b0; w_ack = 1'b0; w_rdata = 32'h0;
    w_reset = 1'b0;
    step();
    vectors++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_fetch: got req=%b addr=%h, want 1/fffffffc", w_req, w_addr);
    end
    w_ack = 1'b1;
    step();
    w_ack = 1'b0;
    vectors++;
    if (w_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_exec: got valid=%b want 1", w_valid);
    end
    step();
    vectors++;
    if (w_pc !== 32'h0 || w_addr !== 32'h0 || w_req !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_pc: got pc=%h addr=%h req=%b, want 00000000/00000000/1", w_pc, w_addr, w_req);
    end
  endtask

  initial begin
    reset = 1'b1; w_reset = 1'b1; PCWre = 1'b1; PCSrc = 1'b0; ExtSel = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; w_ack = 1'b0; w_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_halt();
    test_reset_mid_fetch();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
